// File: rtl/rv_core_pkg.sv
// rv_core_pkg: constants and typedefs shared across the single-cycle RISC
// datapath. The register bank takes its default widths from here.
//   REG_DATA_W : register / data-port width (32)
//   REG_ADDR_W : register address width (3, giving 8 registers)
//   reg_addr_t : register address type
//   reg_data_t : register data type
package rv_core_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : rv_core_pkg

// File: rtl/reg_bank_rdport.sv
// reg_bank_rdport: one asynchronous read port of the register bank.
// Selects one of 2**ADDR_W registers and applies the register-0 zero forcing.
// Optional feature macro: REG_BANK_BYPASS_EN. When it is defined, a pending
// write to the addressed register is forwarded to the output in the same
// cycle. When it is not defined, the write-side ports do not exist, so there
// is no path from the write data to this output.
// Ports:
//   regs_i   : flattened register contents, entry k is at regs_i[k]
//   raddr_i  : read address
//   we_i     : write enable (bypass builds only)
//   rst_i    : synchronous reset (bypass builds only)
//   waddr_i  : write address (bypass builds only)
//   wdata_i  : write data (bypass builds only)
//   rdata_o  : read data, combinational
module reg_bank_rdport
  import rv_core_pkg::*;
#(
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]                  raddr_i,
`ifdef REG_BANK_BYPASS_EN
  input  logic                               we_i,
  input  logic                               rst_i,
  input  logic [ADDR_W-1:0]                  waddr_i,
  input  logic [DATA_W-1:0]                  wdata_i,
`endif
  output logic [DATA_W-1:0]                  rdata_o
);

  always_comb begin
    rdata_o = regs_i[raddr_i];
`ifdef REG_BANK_BYPASS_EN
    // A reset in the same cycle discards the write, so it must not be
    // forwarded either.
    if (we_i && !rst_i && (raddr_i == waddr_i)) begin
      rdata_o = wdata_i;
    end
`endif
    // The hard-wired zero register has priority over the bypass.
    if (ZERO_R0 && (raddr_i == '0)) begin
      rdata_o = '0;
    end
  end

endmodule : reg_bank_rdport

// File: rtl/reg_bank.sv
// reg_bank: 2**ADDR_W x DATA_W general-purpose register file with one
// synchronous write port and two combinational read ports.
// Optional feature macro: REG_BANK_BYPASS_EN (write-through bypass on reads).
// Ports:
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous active-high reset, clears every register
//   we             : write enable
//   waddr, wdata   : write address and data
//   raddr1, raddr2 : read addresses
//   rdata1, rdata2 : read data, combinational
module reg_bank
  import rv_core_pkg::*;
#(
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [NREG-1:0][DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
    // A constant-zero register 0 lets synthesis remove its flops.
    if (ZERO_R0) begin
      regs_d[0] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Both read ports are identical, so they are built from one loop.
  logic [1:0][ADDR_W-1:0] raddr_all;
  logic [1:0][DATA_W-1:0] rdata_all;

  assign raddr_all[0] = raddr1;
  assign raddr_all[1] = raddr2;
  assign rdata1       = rdata_all[0];
  assign rdata2       = rdata_all[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rdport
    reg_bank_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
    ) u_rdport (
      .regs_i  (regs_q),
      .raddr_i (raddr_all[gi]),
`ifdef REG_BANK_BYPASS_EN
      .we_i    (we),
      .rst_i   (rst),
      .waddr_i (waddr),
      .wdata_i (wdata),
`endif
      .rdata_o (rdata_all[gi])
    );
  end

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed bench for reg_bank. One instance has a zero-wired
// register 0 and a second one has an ordinary register 0; they share inputs.
// Expected values go into a queue as each read is set up and are popped and
// compared when the outputs are sampled.
module tb_reg_bank;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] rdata1_nz;
  logic [31:0] rdata2_nz;

  int vectors;
  int miscompares;

  logic [31:0] exp_q[$];
  logic [31:0] model[8];

  reg_bank #(.DATA_W(32), .ADDR_W(3), .ZERO_R0(1'b1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  reg_bank #(.DATA_W(32), .ADDR_W(3), .ZERO_R0(1'b0)) u_dut_nz (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1_nz),
    .rdata2 (rdata2_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is a fixed sequence, so an overrun means something hung.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Write one register; the model honours the zero-wired register 0.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (a != 3'd0) model[a] = d;
  endtask

  // Set both read addresses mid-cycle and compare against the model.
  task automatic rd(input string tag, input logic [2:0] a1, input logic [2:0] a2);
    @(negedge clk);
    raddr1 = a1; raddr2 = a2;
    push(model[a1]);
    push(model[a2]);
    #1;
    chk({tag, "_p1"}, rdata1);
    chk({tag, "_p2"}, rdata2);
    $display("rd %s a1=%0d d1=%h a2=%0d d2=%h", tag, a1, rdata1, a2, rdata2);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: everything reads 0.
    for (int i = 0; i < 8; i++) rd("reset_state", 3'(i), 3'(7 - i));

    // Reset wins over a simultaneous write.
    wr(3'd3, 32'hDEADBEEF);
    rd("pre_reset_r3", 3'd3, 3'd3);
    @(negedge clk);
    rst = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 32'h1234;
    @(posedge clk);
    #1 rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 0; i < 8; i++) rd("mid_reset", 3'(i), 3'(i));

    // Write r1..r7 and sweep both ports, aligned and offset.
    for (int i = 1; i < 8; i++) wr(3'(i), 32'h11111111 * i);
    for (int i = 0; i < 8; i++) rd("sweep_same", 3'(i), 3'(i));
    for (int i = 0; i < 8; i++) rd("sweep_cross", 3'(i), 3'((i + 3) % 8));

    // Register 0 write: ignored when zero-wired, stored otherwise.
    wr(3'd0, 32'hFFFFFFFF);
    rd("r0_zero", 3'd0, 3'd0);
    push(32'hFFFFFFFF);
    chk("r0_plain", rdata1_nz);
    $display("rd r0_plain d=%h", rdata1_nz);

    // Zero-wired register 0 stays 0 even with a pending write to it.
    @(negedge clk);
    we = 1'b1; waddr = 3'd0; wdata = 32'h77; raddr1 = 3'd0; raddr2 = 3'd0;
    push(32'h0);
`ifdef REG_BANK_BYPASS_EN
    push(32'h77);
`else
    push(32'hFFFFFFFF);
`endif
    #1;
    chk("r0_zero_pending", rdata1);
    chk("r0_plain_pending", rdata2_nz);
    $display("rd r0_pending zero=%h plain=%h", rdata1, rdata2_nz);
    we = 1'b0;

    // Same-cycle read-after-write on both ports.
    wr(3'd2, 32'hA);
    @(negedge clk);
    we = 1'b1; waddr = 3'd2; wdata = 32'hB; raddr1 = 3'd2; raddr2 = 3'd2;
`ifdef REG_BANK_BYPASS_EN
    push(32'hB); push(32'hB);
`else
    push(32'hA); push(32'hA);
`endif
    #1;
    chk("raw_before_p1", rdata1);
    chk("raw_before_p2", rdata2);
    $display("rd raw_before d1=%h d2=%h", rdata1, rdata2);
    @(posedge clk);
    #1 we = 1'b0;
    model[2] = 32'hB;
    rd("raw_after", 3'd2, 3'd2);

    // we=0 hold on r4 for three cycles.
    @(negedge clk);
    waddr = 3'd4; wdata = 32'h5555; we = 1'b0;
    for (int c = 0; c < 3; c++) rd("hold_r4", 3'd4, 3'd4);

    // Back-to-back writes to r6; sample after each edge before moving on.
    @(negedge clk);
    raddr1 = 3'd6; raddr2 = 3'd6; we = 1'b1; waddr = 3'd6;
    for (int k = 1; k <= 3; k++) begin
      wdata = 32'(k);
      push(32'(k)); push(32'(k));
      @(posedge clk);
      #1;
      chk("b2b_r6_p1", rdata1);
      chk("b2b_r6_p2", rdata2);
      $display("rd b2b_r6 k=%0d d1=%h d2=%h", k, rdata1, rdata2);
    end
    we = 1'b0;
    model[6] = 32'h3;
    rd("final_r6_r7", 3'd6, 3'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_bank
